stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Time-keeping and mode controller for the stopwatch display path. It owns the four BCD digits (min_l, min_r, sec_l, sec_r) that feed the seven-segment multiplexer, and the per-digit blank mask that multiplexer applies. It counts at 1 Hz, handles run/pause/clear, and provides an adjust mode in which the selected field steps at 2 Hz and blinks.

## Interface
- TICKS_PER_SEC, 100_000_000: clk cycles per second. Must be even and ≥ 4.
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_pause  in  1  single-cycle pulse, already debounced; toggles RUN/PAUSE.
- btn_clear  in  1  single-cycle pulse, already debounced; zeroes the time.
- adj  in  1  level; 1 selects ADJUST mode.
- sel  in  1  level; field to adjust: 0 = minutes, 1 = seconds.
- min_l, min_r, sec_l, sec_r  out  4 each  BCD digits, registered.
- blank  out  4  per-digit blank mask, registered; 1 = dark. Bit order: [3]=min_l, [2]=min_r, [1]=sec_l, [0]=sec_r.
- running  out  1  1 while in RUN state.

## Operation
- States: PAUSE, RUN, ADJUST. The reset state is PAUSE.
- Reset values:
  - all digits 0
  - blank = 4'b0000
  - running = 0
  - prescaler = 0
  - half = 0
- Prescaler:
  - Counts 0..TICKS_PER_SEC/2-1; at the terminal value it wraps to 0 and raises a half-second pulse.
  - The `half` bit toggles on each half-second pulse.
  - A one-second tick is a half-second pulse with half = 1.
- PAUSE:
  - btn_pause → RUN.
  - Prescaler holds, so fractional seconds are preserved on resume.
- RUN:
  - The prescaler counts.
  - On each tick, seconds increment; 59 → 00 carries into minutes.
  - Minutes 59 → 00 with no further carry, so 59:59 → 00:00.
  - btn_pause → PAUSE.
- ADJUST:
  - Entered from any state when adj = 1; exited to PAUSE when adj = 0.
  - On entry and on exit, the prescaler and half are zeroed.
  - The prescaler free-runs. Each half-second pulse increments the selected field by 1 (59 → 00), with no carry between fields.
  - The unselected field holds its value.
  - blank is 2'b11 on the selected field's two bits while half = 1, and 0 otherwise.
  - btn_pause is ignored.
- blank is 0 outside ADJUST.
- btn_clear:
  - In any state: digits → 00:00, prescaler and half → 0. State is unchanged (RUN continues from 00:00).
- Field arithmetic:
  - Each field is a two-digit BCD counter: the ones digit 0..9 and the tens digit 0..5.
  - Digits never hold values above 9 or tens values above 5.

## Timing
- Output latency: outputs are registered and change on the edge after the condition is sampled.
- btn_pause sampled at edge k:
  - running = 1 after edge k.
  - The first seconds increment is visible after edge k + TICKS_PER_SEC, when resuming from prescaler = 0.
- Simultaneous events, highest priority first:
  1. Reset.
  2. adj transition.
  3. btn_clear.
  4. Tick / step.
  5. btn_pause.
- Specific cases:
  - btn_clear together with a tick: the result is 00:00.
  - btn_clear together with btn_pause: both take effect.
  - adj rising together with btn_pause: enters ADJUST; the pause is discarded.
  - sel changing mid-ADJUST: takes effect on the next step. The blank mask moves on the edge after the sel change.
- Asynchronous reset mid-count: all outputs take their reset values immediately, independent of clk.

## Structure
- stopwatch_pkg holds:
  - the state enum (PAUSE, RUN, ADJUST)
  - the BCD limit constants (ONES_MAX = 9, TENS_MAX = 5)
  - the blank bit-index constants
- Sub-module bcd_mod60:
  - Ports: clk, rst_n, inc, clr, tens[3:0], ones[3:0], carry.
  - carry is combinational and is high when inc is asserted at 59.
  - Instantiated twice: minutes and seconds.
  - In RUN, the seconds carry drives the minutes inc.
- Prescaler and FSM live in the top module.

## Test plan
All scenarios use TICKS_PER_SEC = 4.
- Reset → PAUSE:
  - After reset release: digits 0,0,0,0; blank = 0; running = 0.
  - 20 cycles with no stimulus: all unchanged.
- btn_pause, then 60 × 4 cycles → 01:00 and running = 1. A further btn_pause freezes the digits.
- Preload 59:58 via ADJUST, then RUN 8 cycles → 00:00 with no spurious intermediate digit values above 9 or 5.
- ADJUST:
  - sel = 1, hold 6 half-seconds (12 cycles) from sec 57 → 03; minutes unchanged.
  - blank[1:0] alternates 11/00 every 2 cycles.
  - blank[3:2] = 00 throughout.
- Simultaneous events:
  - btn_clear on the same cycle as a tick at 00:09 → 00:00.
  - adj rising together with btn_pause → ADJUST, running = 0.
- rst_n asserted mid-RUN at 03:27 → outputs zero asynchronously, before the next clk edge. After release: PAUSE.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch time-keeping path.
package stopwatch_pkg;

    // Controller modes; PAUSE is the reset state.
    typedef enum logic [1:0] {
        PAUSE  = 2'd0,
        RUN    = 2'd1,
        ADJUST = 2'd2
    } state_t;

    // Largest legal value of each BCD digit of a 00..59 field.
    localparam logic [3:0] ONES_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX = 4'd5;

    // Bit positions of each digit inside the blank mask.
    localparam int BLANK_MIN_L = 3;
    localparam int BLANK_MIN_R = 2;
    localparam int BLANK_SEC_L = 1;
    localparam int BLANK_SEC_R = 0;

    // Blank mask that darkens both digits of the field being adjusted.
    function automatic logic [3:0] field_blank_mask(input logic sel_sec);
        logic [3:0] mask;
        mask = '0;
        if (sel_sec) begin
            mask[BLANK_SEC_L] = 1'b1;
            mask[BLANK_SEC_R] = 1'b1;
        end else begin
            mask[BLANK_MIN_L] = 1'b1;
            mask[BLANK_MIN_R] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_mod60.sv
// Two-digit BCD counter 00..59 with synchronous clear; used for minutes and seconds.
module bcd_mod60
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry
);

    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic       w_at_max;

    assign w_at_max = (r_ones == ONES_MAX) && (r_tens == TENS_MAX);
    // Rollover indication is combinational so the next field steps on the same edge.
    assign carry    = inc && w_at_max;
    assign tens     = r_tens;
    assign ones     = r_ones;

    // Digit registers: clear wins over increment; ones wrap 9->0 and bump tens, tens wrap 5->0.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tens <= '0;
            r_ones <= '0;
        end else if (clr) begin
            r_tens <= '0;
            r_ones <= '0;
        end else if (inc) begin
            if (r_ones == ONES_MAX) begin
                r_ones <= '0;
                r_tens <= (r_tens == TENS_MAX) ? 4'd0 : r_tens + 4'd1;
            end else begin
                r_ones <= r_ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: half-second prescaler, PAUSE/RUN/ADJUST FSM,
// minutes/seconds BCD fields and the per-digit blink mask.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_pause,
    input  logic       btn_clear,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_l,
    output logic [3:0] min_r,
    output logic [3:0] sec_l,
    output logic [3:0] sec_r,
    output logic [3:0] blank,
    output logic       running
);

    localparam int             HALF_TICKS = TICKS_PER_SEC / 2;
    localparam int             PW         = (HALF_TICKS > 1) ? $clog2(HALF_TICKS) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(HALF_TICKS - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_next;
    logic          r_half;
    logic          w_half_next;
    logic [3:0]    r_blank;
    logic          r_running;

    logic          w_adj_enter;
    logic          w_adj_exit;
    logic          w_adj_evt;
    logic          w_counting;
    logic          w_half_pulse;
    logic          w_tick;
    logic          w_clr;
    logic          w_sec_inc;
    logic          w_min_inc;
    logic          w_sec_carry;
    logic          w_min_carry;

    // Event decode: an adj transition outranks clear, clear outranks counting, counting outranks pause.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        w_adj_enter  = adj && (r_state != ADJUST);
        w_adj_exit   = !adj && (r_state == ADJUST);
        w_adj_evt    = w_adj_enter || w_adj_exit;
        w_clr        = btn_clear && !w_adj_evt;
        w_counting   = !w_adj_evt && !btn_clear && ((r_state == RUN) || (r_state == ADJUST));
        w_half_pulse = w_counting && (r_presc == PRESC_LAST);
        w_tick       = w_half_pulse && r_half;

        // Seconds step on a full tick in RUN or on each half-second when selected in ADJUST.
        w_sec_inc = ((r_state == RUN) && w_tick) ||
                    ((r_state == ADJUST) && w_half_pulse && sel);
        // Minutes take the seconds carry only in RUN; ADJUST fields are independent.
        w_min_inc = ((r_state == RUN) && w_sec_carry) ||
                    ((r_state == ADJUST) && w_half_pulse && !sel);
    end

    // Prescaler next value: zeroed on adj transitions and clear, held while paused.
    always_comb begin
        w_presc_next = r_presc;
        w_half_next  = r_half;
        if (w_adj_evt || btn_clear) begin
            w_presc_next = '0;
            w_half_next  = 1'b0;
        end else if (w_counting) begin
            if (r_presc == PRESC_LAST) begin
                w_presc_next = '0;
                w_half_next  = !r_half;
            end else begin
                w_presc_next = r_presc + PW'(1);
            end
        end
    end

    // Mode next-state: adj transitions first; btn_pause toggles PAUSE/RUN and is ignored in ADJUST.
    always_comb begin
        w_state_next = r_state;
        if (w_adj_enter) begin
            w_state_next = ADJUST;
        end else if (w_adj_exit) begin
            w_state_next = PAUSE;
        end else if (btn_pause) begin
            case (r_state)
                PAUSE:   w_state_next = RUN;
                RUN:     w_state_next = PAUSE;
                default: w_state_next = r_state;
            endcase
        end
    end

    // Prescaler and half-second phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_half  <= 1'b0;
        end else begin
            r_presc <= w_presc_next;
            r_half  <= w_half_next;
        end
    end

    // FSM with registered outputs derived from the next state so they align with the mode change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= PAUSE;
            r_running <= 1'b0;
            r_blank   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_running <= (w_state_next == RUN);
            r_blank   <= ((w_state_next == ADJUST) && w_half_next) ? field_blank_mask(sel) : 4'b0000;
        end
    end

    bcd_mod60 u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_sec_inc),
        .clr   (w_clr),
        .tens  (sec_l),
        .ones  (sec_r),
        .carry (w_sec_carry)
    );

    bcd_mod60 u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_min_inc),
        .clr   (w_clr),
        .tens  (min_l),
        .ones  (min_r),
        .carry (w_min_carry)
    );

    assign blank   = r_blank;
    assign running = r_running;

    // Minutes roll 59 -> 00 with nothing further to carry into.
    logic w_unused;
    assign w_unused = w_min_carry;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed, table-driven bench for stopwatch_ctrl with TICKS_PER_SEC = 4.
module tb_stopwatch_ctrl;

    logic       clk;
    logic       rst_n;
    logic       btn_pause;
    logic       btn_clear;
    logic       adj;
    logic       sel;
    logic [3:0] min_l;
    logic [3:0] min_r;
    logic [3:0] sec_l;
    logic [3:0] sec_r;
    logic [3:0] blank;
    logic       running;
    logic [15:0] digits;

    int n_vec = 0;
    int n_err = 0;

    stopwatch_ctrl #(.TICKS_PER_SEC(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_pause (btn_pause),
        .btn_clear (btn_clear),
        .adj       (adj),
        .sel       (sel),
        .min_l     (min_l),
        .min_r     (min_r),
        .sec_l     (sec_l),
        .sec_r     (sec_r),
        .blank     (blank),
        .running   (running)
    );

    assign digits = {min_l, min_r, sec_l, sec_r};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        pause;
        logic        clr;
        logic        adj;
        logic        sel;
        logic [15:0] digits;
        logic [3:0]  blank;
        logic        running;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // One clock edge, then settle 1 ns so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        btn_pause = 1'b0;
        btn_clear = 1'b0;
        adj       = 1'b0;
        sel       = 1'b0;
        rst_n     = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic set_vec(input int i, input logic p, input logic c, input logic a, input logic s,
                           input logic [15:0] d, input logic [3:0] b, input logic r);
        vecs[i] = '{pause: p, clr: c, adj: a, sel: s, digits: d, blank: b, running: r};
    endtask

    task automatic check_range(input string name);
        logic ok;
        ok = (min_l <= 4'd5) && (min_r <= 4'd9) && (sec_l <= 4'd5) && (sec_r <= 4'd9);
        check(name, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        //            p  c  a  s  digits    blank    run
        set_vec( 0, 1, 0, 0, 0, 16'h0000, 4'b0000, 1);  // PAUSE -> RUN
        set_vec( 1, 0, 0, 0, 0, 16'h0000, 4'b0000, 1);
        set_vec( 2, 0, 0, 0, 0, 16'h0000, 4'b0000, 1);
        set_vec( 3, 0, 0, 0, 0, 16'h0000, 4'b0000, 1);
        set_vec( 4, 0, 0, 0, 0, 16'h0001, 4'b0000, 1);  // first tick at k+4
        set_vec( 5, 0, 0, 0, 0, 16'h0001, 4'b0000, 1);
        set_vec( 6, 0, 0, 0, 0, 16'h0001, 4'b0000, 1);
        set_vec( 7, 0, 0, 0, 0, 16'h0001, 4'b0000, 1);
        set_vec( 8, 0, 0, 0, 0, 16'h0002, 4'b0000, 1);
        set_vec( 9, 0, 0, 1, 1, 16'h0002, 4'b0000, 0);  // enter ADJUST on seconds
        set_vec(10, 0, 0, 1, 1, 16'h0002, 4'b0000, 0);
        set_vec(11, 0, 0, 1, 1, 16'h0003, 4'b0011, 0);  // step + blink on
        set_vec(12, 0, 0, 1, 1, 16'h0003, 4'b0011, 0);
        set_vec(13, 0, 0, 1, 1, 16'h0004, 4'b0000, 0);
        set_vec(14, 0, 0, 1, 0, 16'h0004, 4'b0000, 0);  // switch to minutes
        set_vec(15, 0, 0, 1, 0, 16'h0104, 4'b1100, 0);
        set_vec(16, 0, 0, 0, 0, 16'h0104, 4'b0000, 0);  // exit to PAUSE
        set_vec(17, 0, 1, 0, 0, 16'h0000, 4'b0000, 0);  // clear in PAUSE
        set_vec(18, 1, 1, 0, 0, 16'h0000, 4'b0000, 1);  // clear + pause both act
        set_vec(19, 1, 0, 1, 0, 16'h0000, 4'b0000, 0);  // adj rise wins over pause

        rst_n     = 1'b0;
        btn_pause = 1'b0;
        btn_clear = 1'b0;
        adj       = 1'b0;
        sel       = 1'b0;

        // Reset state and idle hold.
        do_reset();
        check("rst_digits", {16'd0, digits}, 32'h0000);
        check("rst_blank", {28'd0, blank}, 32'd0);
        check("rst_running", {31'd0, running}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("idle%0d", i), {11'd0, running, blank, digits}, 32'd0);
        end

        // Table-driven vectors.
        for (int i = 0; i < 20; i++) begin
            btn_pause = vecs[i].pause;
            btn_clear = vecs[i].clr;
            adj       = vecs[i].adj;
            sel       = vecs[i].sel;
            step();
            check($sformatf("vec%0d_digits", i), {16'd0, digits}, {16'd0, vecs[i].digits});
            check($sformatf("vec%0d_blank", i), {28'd0, blank}, {28'd0, vecs[i].blank});
            check($sformatf("vec%0d_running", i), {31'd0, running}, {31'd0, vecs[i].running});
        end
        btn_pause = 1'b0;
        adj       = 1'b0;

        // Run one full minute, then freeze.
        do_reset();
        btn_pause = 1'b1;
        step();
        btn_pause = 1'b0;
        repeat (240) step();
        check("minute_digits", {16'd0, digits}, 32'h0100);
        check("minute_running", {31'd0, running}, 32'd1);
        btn_pause = 1'b1;
        step();
        btn_pause = 1'b0;
        check("freeze_running", {31'd0, running}, 32'd0);
        repeat (10) step();
        check("freeze_digits", {16'd0, digits}, 32'h0100);

        // Preload 59:58 in ADJUST, then roll over to 00:00 in RUN.
        do_reset();
        adj = 1'b1;
        sel = 1'b0;
        step();
        repeat (118) step();
        check("preload_min", {16'd0, digits}, 32'h5900);
        sel = 1'b1;
        repeat (116) step();
        check("preload_sec", {16'd0, digits}, 32'h5958);
        adj = 1'b0;
        step();
        check("preload_exit_blank", {28'd0, blank}, 32'd0);
        btn_pause = 1'b1;
        step();
        btn_pause = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            check_range($sformatf("roll_range%0d", i));
            if (i == 4) check("roll_5959", {16'd0, digits}, 32'h5959);
            if (i == 8) check("roll_0000", {16'd0, digits}, 32'h0000);
        end

        // ADJUST seconds 57 -> 03 with blink pattern.
        do_reset();
        adj = 1'b1;
        sel = 1'b1;
        step();
        repeat (114) step();
        check("adj_sec57", {16'd0, digits}, 32'h0057);
        adj = 1'b0;
        step();
        adj = 1'b1;
        step();
        for (int i = 1; i <= 12; i++) begin
            step();
            check($sformatf("blink%0d", i), {28'd0, blank},
                  ((i % 4 == 2) || (i % 4 == 3)) ? 32'h3 : 32'h0);
        end
        check("adj_sec03", {16'd0, digits}, 32'h0003);
        adj = 1'b0;
        step();

        // Clear coinciding with a tick at 00:09.
        do_reset();
        btn_pause = 1'b1;
        step();
        btn_pause = 1'b0;
        repeat (39) step();
        check("pre_clear", {16'd0, digits}, 32'h0009);
        btn_clear = 1'b1;
        step();
        btn_clear = 1'b0;
        check("clear_tick", {16'd0, digits}, 32'h0000);
        check("clear_running", {31'd0, running}, 32'd1);
        repeat (4) step();
        check("after_clear", {16'd0, digits}, 32'h0001);

        // Asynchronous reset mid-RUN at 03:27.
        do_reset();
        btn_pause = 1'b1;
        step();
        btn_pause = 1'b0;
        repeat (828) step();
        check("at_0327", {16'd0, digits}, 32'h0327);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_digits", {16'd0, digits}, 32'h0000);
        check("async_running", {31'd0, running}, 32'd0);
        check("async_blank", {28'd0, blank}, 32'd0);
        step();
        rst_n = 1'b1;
        repeat (8) step();
        check("post_rst_pause", {11'd0, running, blank, digits}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
